const_f2i_search: RTL and testbench
===================================

CONST_F2I_SEARCH -- requirements
Module: const_f2i_search

Interface
REQ-001 Parameter: EARLY_EXIT, default 1, 1 = stop at first match, 0 = always scan all 8 entries.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request; sampled only in IDLE.
REQ-005 Port: value_in  input  8  constant to reverse-look-up; sampled with start.
REQ-006 Port: busy  output  1  high while in SEARCH.
REQ-007 Port: done  output  1  one-cycle pulse marking a valid result.
REQ-008 Port: hit  output  1  1 = value found in the table.
REQ-009 Port: index_out  output  3  table index of the match; 0 on miss.

Function
REQ-010 Table contents, index->value: 0->8'd1, 1->8'd2, 2->8'd15, 3->8'hFF, 4->8'h7F, 5->8'd10, 6->8'd6, 7->8'd5. All entries are distinct.
REQ-011 FSM states: IDLE, SEARCH, DONE.
REQ-012 IDLE with start=1: value_in is latched into value_q, idx is cleared to 0, hit_q and index_q are cleared, and the next state is SEARCH.
REQ-013 IDLE with start=0: the FSM remains in IDLE.
REQ-014 SEARCH: one table entry is compared per cycle, table[idx] against value_q.
REQ-015 SEARCH, on a match while hit_q=0: hit_q is set to 1 and index_q is set to idx.
REQ-016 SEARCH with EARLY_EXIT=1 and a match: the next state is DONE.
REQ-017 SEARCH with idx=7: the next state is DONE regardless of match.
REQ-018 SEARCH otherwise: idx increments by 1 and the FSM stays in SEARCH.
REQ-019 idx never wraps; the idx=7 exit takes priority over the increment.
REQ-020 DONE: done=1 for exactly one cycle, then the next state is IDLE unconditionally.
REQ-021 start is ignored in SEARCH and DONE; no queuing occurs.
REQ-022 A new start is accepted no earlier than the cycle after the done pulse.
REQ-023 hit and index_out are driven from hit_q and index_q.
REQ-024 hit and index_out are valid while done=1 and hold until the next accepted start clears them.
REQ-025 Latency with EARLY_EXIT=1: a match at index k raises done k+2 rising edges after the edge that sampled start. A miss raises done at 9 edges.
REQ-026 Latency with EARLY_EXIT=0: done is always raised at 9 edges; the lowest matching index is reported.
REQ-027 busy=1 exactly when the state is SEARCH.
REQ-028 done is a registered output decoded from state DONE; there is no combinational path from the inputs to any output.

Reset
REQ-029 reset_n=0 forces state=IDLE, idx=0, value_q=0, hit=0, index_out=0, busy=0 and done=0 immediately, without waiting for clk.
REQ-030 Reset asserted mid-SEARCH or in DONE aborts the operation; no done pulse is produced.
REQ-031 After reset deasserts, the first rising edge with start=1 is accepted.

Structure
REQ-032 The 8-entry table (array of 8-bit constants indexed by 3 bits) belongs in shared package const_pkg.
REQ-033 The FSM state enum type const_srch_state_t belongs in const_pkg.
REQ-034 No sub-module; the comparator and counter are inline, with one FSM and one datapath process.

Verification
REQ-035 Start with value_in=8'd1 (EARLY_EXIT=1) -> done at edge 2, hit=1, index_out=0, busy high for 1 cycle.
REQ-036 Start with value_in=8'd5 -> done at edge 9, hit=1, index_out=7; idx does not wrap.
REQ-037 Start with value_in=8'd3 -> done at edge 9, hit=0, index_out=0.
REQ-038 With EARLY_EXIT=0, start with value_in=8'h7F -> done at edge 9, hit=1, index_out=4.
REQ-039 Start 8'hFF, assert start again with 8'd2 during SEARCH -> the second start is ignored and the result is index_out=3. Start with 8'd2 the cycle after done -> index_out=1.
REQ-040 Start 8'd6, pulse reset_n low mid-SEARCH -> outputs are 0 immediately and no done occurs. A new start with 8'd10 -> index_out=5.

Source files
------------

// File: rtl/const_pkg.sv
// Shared constants for the constant reverse-lookup search: table contents and FSM state type.
package const_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_DONE
  } const_srch_state_t;

  localparam logic [7:0] CONST_TABLE [8] = '{
    8'd1, 8'd2, 8'd15, 8'hFF, 8'h7F, 8'd10, 8'd6, 8'd5
  };

endpackage

// File: rtl/const_f2i_search.sv
// Sequential reverse lookup of an 8-bit constant in CONST_TABLE, one entry per cycle,
// reporting the lowest matching index.
module const_f2i_search
  import const_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] value_in,
  output logic       busy,
  output logic       done,
  output logic       hit,
  output logic [2:0] index_out
);

  const_srch_state_t state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] value_q, value_d;
  logic       hit_q, hit_d;
  logic [2:0] index_q, index_d;
  logic       done_q, done_d;
  logic       match;
  logic       last;

  assign match = (CONST_TABLE[idx_q] == value_q);
  assign last  = (idx_q == 3'd7);

  // FSM: next state and the done pulse, registered one cycle after the DONE state
  always_comb begin
    state_d = state_q;
    done_d  = (state_q == ST_DONE);
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_SEARCH;
      ST_SEARCH: if (last || (EARLY_EXIT && match)) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath: operand latch, index counter and first-match capture
  always_comb begin
    idx_d   = idx_q;
    value_d = value_q;
    hit_d   = hit_q;
    index_d = index_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          value_d = value_in;
          idx_d   = '0;
          hit_d   = 1'b0;
          index_d = '0;
        end
      end
      ST_SEARCH: begin
        if (match && !hit_q) begin
          hit_d   = 1'b1;
          index_d = idx_q;
        end
        if (!(last || (EARLY_EXIT && match))) idx_d = idx_q + 3'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      value_q <= '0;
      hit_q   <= 1'b0;
      index_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      value_q <= value_d;
      hit_q   <= hit_d;
      index_q <= index_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q == ST_SEARCH);
  assign done      = done_q;
  assign hit       = hit_q;
  assign index_out = index_q;

endmodule

// File: tb/tb_const_f2i_search.sv
// Directed bench for const_f2i_search: an early-exit and a full-scan instance, scoreboarded results.
module tb_const_f2i_search;

  typedef struct {
    logic       hit;
    logic [2:0] idx;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start_s [2];
  logic [7:0] val_s   [2];
  logic       busy_s  [2];
  logic       done_s  [2];
  logic       hit_s   [2];
  logic [2:0] idx_s   [2];

  exp_t sb [$];
  int   nvec = 0;
  int   nerr = 0;

  logic [7:0] ref_table [8] = '{8'd1, 8'd2, 8'd15, 8'hFF, 8'h7F, 8'd10, 8'd6, 8'd5};

  always #5 clk = ~clk;

  const_f2i_search #(.EARLY_EXIT(1'b1)) u_early (
    .clk(clk), .reset_n(reset_n), .start(start_s[0]), .value_in(val_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .hit(hit_s[0]), .index_out(idx_s[0])
  );

  const_f2i_search #(.EARLY_EXIT(1'b0)) u_full (
    .clk(clk), .reset_n(reset_n), .start(start_s[1]), .value_in(val_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .hit(hit_s[1]), .index_out(idx_s[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input bit early, input logic [7:0] v);
    exp_t e;
    e.hit = 1'b0;
    e.idx = '0;
    e.lat = 9;
    for (int i = 0; i < 8; i++) begin
      if (ref_table[i] == v) begin
        e.hit = 1'b1;
        e.idx = 3'(i);
        e.lat = early ? i + 2 : 9;
        return e;
      end
    end
    return e;
  endfunction

  task automatic search(input int sel, input logic [7:0] v, input logic exp_hit,
                        input logic [2:0] exp_idx, input int exp_lat,
                        input bit inject, input logic [7:0] inj_val);
    exp_t e;
    int   lat;
    bit   got;
    e.hit = exp_hit;
    e.idx = exp_idx;
    e.lat = exp_lat;
    sb.push_back(e);
    @(negedge clk);
    start_s[sel] = 1'b1;
    val_s[sel]   = v;
    @(negedge clk);
    start_s[sel] = 1'b0;
    val_s[sel]   = 8'($urandom);
    chk("busy_after_start", 32'(busy_s[sel]), 32'd1);
    lat = 0;
    got = 1'b0;
    while (lat < 20 && !got) begin
      @(negedge clk);
      lat++;
      if (inject && lat == 2) begin
        start_s[sel] = 1'b1;
        val_s[sel]   = inj_val;
      end else if (inject && lat == 3) begin
        start_s[sel] = 1'b0;
      end
      if (done_s[sel] === 1'b1) got = 1'b1;
      else chk("busy_during", 32'(busy_s[sel]), 32'(lat <= exp_lat - 2));
    end
    start_s[sel] = 1'b0;
    e = sb.pop_front();
    if (!got) begin
      chk("done_timeout", 32'd0, 32'd1);
      return;
    end
    chk("latency", 32'(lat), 32'(e.lat));
    chk("hit", 32'(hit_s[sel]), 32'(e.hit));
    chk("index_out", 32'(idx_s[sel]), 32'(e.idx));
    chk("busy_at_done", 32'(busy_s[sel]), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", 32'(done_s[sel]), 32'd0);
    chk("hit_hold", 32'(hit_s[sel]), 32'(e.hit));
    chk("index_hold", 32'(idx_s[sel]), 32'(e.idx));
  endtask

  task automatic chk_zero(input int sel, input string tag);
    chk({tag, "_busy"}, 32'(busy_s[sel]), 32'd0);
    chk({tag, "_done"}, 32'(done_s[sel]), 32'd0);
    chk({tag, "_hit"}, 32'(hit_s[sel]), 32'd0);
    chk({tag, "_index"}, 32'(idx_s[sel]), 32'd0);
  endtask

  initial begin
    exp_t e;
    bit   saw_done;
    logic [7:0] rv;
    reset_n    = 1'b0;
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    val_s[0]   = '0;
    val_s[1]   = '0;
    #1;
    chk_zero(0, "reset_early");
    chk_zero(1, "reset_full");
    @(negedge clk);
    reset_n = 1'b1;

    search(0, 8'd1, 1'b1, 3'd0, 2, 1'b0, 8'd0);
    search(0, 8'd5, 1'b1, 3'd7, 9, 1'b0, 8'd0);
    search(0, 8'd3, 1'b0, 3'd0, 9, 1'b0, 8'd0);
    search(1, 8'h7F, 1'b1, 3'd4, 9, 1'b0, 8'd0);
    search(0, 8'hFF, 1'b1, 3'd3, 5, 1'b1, 8'd2);
    search(0, 8'd2, 1'b1, 3'd1, 3, 1'b0, 8'd0);

    for (int i = 0; i < 8; i++) begin
      e = model(1'b0, ref_table[i]);
      search(1, ref_table[i], e.hit, e.idx, e.lat, 1'b0, 8'd0);
    end
    for (int i = 0; i < 6; i++) begin
      rv = (i % 2 == 0) ? ref_table[$urandom_range(7, 0)] : 8'($urandom);
      e  = model(1'b1, rv);
      search(0, rv, e.hit, e.idx, e.lat, 1'b0, 8'd0);
    end

    // Abort mid-search; the full-scan instance still holds a hit that reset must clear at once
    search(1, 8'd15, 1'b1, 3'd2, 9, 1'b0, 8'd0);
    @(negedge clk);
    start_s[0] = 1'b1;
    val_s[0]   = 8'd6;
    @(negedge clk);
    start_s[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("busy_before_abort", 32'(busy_s[0]), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_zero(0, "abort_early");
    chk_zero(1, "abort_full");
    @(negedge clk);
    reset_n  = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done_s[0] !== 1'b0) saw_done = 1'b1;
    end
    chk("no_done_after_abort", 32'(saw_done), 32'd0);
    search(0, 8'd10, 1'b1, 3'd5, 7, 1'b0, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
